// File: rtl/sd_fifo_mem_sched.sv
// sd_fifo_mem_sched: round-robin scheduler for one single-port FIFO memory
// shared by `ports` channels, with up to `burst` consecutive grants per owner.
// Requester r=2i is head (write) i, r=2i+1 is tail (read) i.
// Grants are combinational from the requests; only the pointer and the
// burst-hold state are registered.
// Optional macro SDLIB_SCHED_RDPRIO_EN: strict read priority (tails pre-empt heads).
module sd_fifo_mem_sched #(
   parameter int unsigned ports = 4,
   parameter int unsigned burst = 4,
   parameter int unsigned psz   = (ports > 1) ? $clog2(ports) : 1,
   parameter int unsigned rsz   = $clog2(2 * ports)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ports-1:0] head_req,
   input  logic [ports-1:0] tail_req,
   output logic [ports-1:0] head_en,
   output logic [ports-1:0] tail_en,
   output logic             gnt_valid,
   output logic [psz-1:0]   gnt_id,
   output logic             gnt_rd
);

   localparam int unsigned N  = 2 * ports;
   localparam int unsigned CW = $clog2(burst + 1);

   typedef enum logic {IDLE, HOLD} fsm_e;

   fsm_e            fsm_q, fsm_d;
   logic [rsz-1:0]  rr_ptr_q, rr_ptr_d;
   logic [rsz-1:0]  owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [N-1:0]    elig;
   logic            found;
   logic [rsz-1:0]  win_r;
   logic            keep;
   logic            grant_v;
   logic [rsz-1:0]  grant_r;

   // Requesters allowed to compete this cycle, interleaved head/tail
`ifdef SDLIB_SCHED_RDPRIO_EN
   logic any_tail;
   assign any_tail = |tail_req;
   for (genvar i = 0; i < ports; i++) begin : g_elig
      assign elig[2*i]   = head_req[i] & ~any_tail;
      assign elig[2*i+1] = tail_req[i];
   end
`else
   for (genvar i = 0; i < ports; i++) begin : g_elig
      assign elig[2*i]   = head_req[i];
      assign elig[2*i+1] = tail_req[i];
   end
`endif

   // Burst continuation: owner still eligible and under its cycle budget
   assign keep = (fsm_q == HOLD) && elig[owner_q] && (int'(cnt_q) < int'(burst));

   // Round-robin search starting at rr_ptr, wrapping at N (not a power of 2)
   always_comb begin
      int idx;
      found = 1'b0;
      win_r = '0;
      idx   = 0;
      for (int k = 0; k < int'(N); k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= int'(N)) idx = idx - int'(N);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win_r = rsz'(idx);
         end
      end
   end

   // Grant selection and next-state for pointer / hold state
   always_comb begin
      fsm_d    = fsm_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      grant_v  = 1'b0;
      grant_r  = '0;
      if (keep) begin
         grant_v = 1'b1;
         grant_r = owner_q;
         cnt_d   = cnt_q + CW'(1);
      end else if (found) begin
         grant_v  = 1'b1;
         grant_r  = win_r;
         rr_ptr_d = (win_r == rsz'(N - 1)) ? '0 : win_r + rsz'(1);
         if (burst > 1) begin
            fsm_d   = HOLD;
            owner_d = win_r;
            cnt_d   = CW'(1);
         end else begin
            fsm_d = IDLE;
         end
      end else begin
         fsm_d = IDLE;
      end
   end

   // One-hot enables and grant descriptors, forced low during reset
   always_comb begin
      head_en   = '0;
      tail_en   = '0;
      gnt_valid = 1'b0;
      gnt_id    = '0;
      gnt_rd    = 1'b0;
      if (reset && grant_v) begin
         gnt_valid = 1'b1;
         gnt_id    = psz'(grant_r >> 1);
         gnt_rd    = grant_r[0];
         for (int i = 0; i < int'(ports); i++) begin
            head_en[i] = (grant_r == rsz'(2 * i));
            tail_en[i] = (grant_r == rsz'(2 * i + 1));
         end
      end
   end

   // Scheduler state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q    <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
      end else begin
         fsm_q    <= fsm_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_sd_fifo_mem_sched.sv
// Scoreboard bench for sd_fifo_mem_sched: two instances (ports=4/burst=4 and
// ports=3/burst=1) driven with directed and random requests; a behavioural
// model queues expected grants, a monitor compares on the falling edge.
`timescale 1ns/1ps
module tb_sd_fifo_mem_sched;

`ifdef SDLIB_SCHED_RDPRIO_EN
   localparam bit RDPRIO = 1'b1;
`else
   localparam bit RDPRIO = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] head;
      logic [7:0] tail;
      logic       valid;
      logic [2:0] id;
      logic       rd;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] h4, t4, he4, te4;
   logic [2:0] h3, t3, he3, te3;
   logic       gv4, gr4, gv3, gr3;
   logic [1:0] gi4, gi3;

   always #5 clk = ~clk;

   sd_fifo_mem_sched #(.ports(4), .burst(4)) dut4 (
      .clk(clk), .reset(reset), .head_req(h4), .tail_req(t4),
      .head_en(he4), .tail_en(te4), .gnt_valid(gv4), .gnt_id(gi4), .gnt_rd(gr4)
   );

   sd_fifo_mem_sched #(.ports(3), .burst(1)) dut3 (
      .clk(clk), .reset(reset), .head_req(h3), .tail_req(t3),
      .head_en(he3), .tail_en(te3), .gnt_valid(gv3), .gnt_id(gi3), .gnt_rd(gr3)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   obs_t q4[$];
   obs_t q3[$];

   // Reference model state, per instance: next search start, current owner,
   // length of the owner's current run, and whether a run is in progress.
   int   nxt[2];
   int   own[2];
   int   run[2];
   bit   inrun[2];

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         nxt[d] = 0; own[d] = 0; run[d] = 0; inrun[d] = 1'b0;
      end
   endfunction

   // One cycle of the scheduling rules: returns the expected grant and
   // advances the model to the state seen at the next rising edge.
   function automatic obs_t model_step(input int d, input int np, input int bu,
                                       input logic [7:0] hr, input logic [7:0] tr);
      obs_t e;
      int   n;
      int   win;
      bit   any_t;
      bit   ok[16];
      n     = 2 * np;
      any_t = (tr != 8'h0);
      for (int r = 0; r < 16; r++) ok[r] = 1'b0;
      for (int r = 0; r < n; r++) begin
         if (r % 2 == 0) ok[r] = hr[r/2] && !(RDPRIO && any_t);
         else            ok[r] = tr[r/2];
      end
      win = -1;
      if (inrun[d] && ok[own[d]] && run[d] < bu) begin
         win    = own[d];
         run[d] = run[d] + 1;
      end else begin
         for (int k = 0; k < n; k++)
            if (win < 0 && ok[(nxt[d] + k) % n]) win = (nxt[d] + k) % n;
         if (win >= 0) begin
            nxt[d]   = (win + 1) % n;
            inrun[d] = (bu > 1);
            own[d]   = win;
            run[d]   = 1;
         end else begin
            inrun[d] = 1'b0;
         end
      end
      e = '0;
      if (win >= 0) begin
         e.valid = 1'b1;
         e.id    = 3'(win / 2);
         e.rd    = (win % 2 == 1);
         if (win % 2 == 1) e.tail[win/2] = 1'b1;
         else              e.head[win/2] = 1'b1;
      end
      return e;
   endfunction

   // Apply one cycle of stimulus shortly after the rising edge and queue expectations
   task automatic drive(input bit rst_v, input logic [3:0] h, input logic [3:0] t,
                        input logic [2:0] hh, input logic [2:0] tt);
      @(posedge clk);
      #2;
      cyc   = cyc + 1;
      reset = rst_v;
      h4 = h; t4 = t; h3 = hh; t3 = tt;
      if (!rst_v) begin
         model_reset();
         q4.push_back('0);
         q3.push_back('0);
      end else begin
         q4.push_back(model_step(0, 4, 4, {4'b0, h}, {4'b0, t}));
         q3.push_back(model_step(1, 3, 1, {5'b0, hh}, {5'b0, tt}));
      end
   endtask

   task automatic compare(input string name, input obs_t a, input obs_t e);
      checks = checks + 1;
      if (a !== e) begin
         errors = errors + 1;
         $display("FAIL %s cyc=%0d got head=%b tail=%b v=%b id=%0d rd=%b want head=%b tail=%b v=%b id=%0d rd=%b",
                  name, cyc, a.head, a.tail, a.valid, a.id, a.rd,
                  e.head, e.tail, e.valid, e.id, e.rd);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation
   initial begin
      obs_t a;
      obs_t e;
      forever begin
         @(negedge clk);
         if (q4.size() > 0) begin
            e = q4.pop_front();
            a = '0;
            a.head = {4'b0, he4}; a.tail = {4'b0, te4};
            a.valid = gv4; a.id = {1'b0, gi4}; a.rd = gr4;
            compare("sched_p4b4", a, e);
         end
         if (q3.size() > 0) begin
            e = q3.pop_front();
            a = '0;
            a.head = {5'b0, he3}; a.tail = {5'b0, te3};
            a.valid = gv3; a.id = {1'b0, gi3}; a.rd = gr3;
            compare("sched_p3b1", a, e);
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic
   initial begin
      logic [3:0] rh, rt;
      logic [2:0] rhh, rtt;
      bit         dense;
      reset = 1'b0;
      h4 = '0; t4 = '0; h3 = '0; t3 = '0;
      model_reset();

      // Requests held during reset, then released into a head rotation
      for (int i = 0; i < 3; i++)  drive(1'b0, 4'hF, 4'h0, 3'h7, 3'h0);
      for (int i = 0; i < 10; i++) drive(1'b1, 4'hF, 4'h0, 3'h7, 3'h0);
      drive(1'b1, 4'h0, 4'h0, 3'h0, 3'h0);

      // Tail 2 vs head 0 alternation; small instance sees all six requesters
      for (int i = 0; i < 17; i++) drive(1'b1, 4'b0001, 4'b0100, 3'h7, 3'h7);

      // Head 1 drops while tail 3 waits: hand-over without a bubble
      for (int i = 0; i < 2; i++) drive(1'b1, 4'b0010, 4'b1000, 3'b010, 3'b000);
      for (int i = 0; i < 2; i++) drive(1'b1, 4'b0000, 4'b1000, 3'b000, 3'b100);

      // Reset in the middle of a tail-1 burst, then restart from r0
      for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000, 4'b0010, 3'b000, 3'b001);
      for (int i = 0; i < 2; i++) drive(1'b0, 4'b0001, 4'b0010, 3'b001, 3'b001);
      for (int i = 0; i < 3; i++) drive(1'b1, 4'b0001, 4'b0010, 3'b001, 3'b001);

      // Single-cycle tail pulse in the middle of a head burst
      for (int i = 0; i < 2; i++) drive(1'b1, 4'hF, 4'h0, 3'h7, 3'h0);
      drive(1'b1, 4'hF, 4'b0010, 3'h7, 3'b001);
      for (int i = 0; i < 3; i++) drive(1'b1, 4'hF, 4'h0, 3'h7, 3'h0);

      // Randomized traffic with occasional resets
      dense = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (i % 25 == 0) dense = ($urandom_range(0, 1) == 1);
         rh  = 4'($urandom) & (dense ? 4'hF : 4'($urandom));
         rt  = 4'($urandom) & (dense ? 4'hF : 4'($urandom));
         rhh = 3'($urandom) & (dense ? 3'h7 : 3'($urandom));
         rtt = 3'($urandom) & (dense ? 3'h7 : 3'($urandom));
         drive(($urandom_range(0, 63) != 0), rh, rt, rhh, rtt);
      end
      drive(1'b1, 4'h0, 4'h0, 3'h0, 3'h0);

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checks = checks + 1;
      if (q4.size() != 0 || q3.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", q4.size(), q3.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_fifo_mem_sched.md
Name: sd_fifo_mem_sched

Overview:
Scheduler sharing one single-port FIFO memory between `ports` FIFO channels.
- Each channel has a head (write) controller and a tail (read) controller.
- The block drives one enable per controller; at most one enable is high per cycle.
- Arbitration is round-robin, with optional burst hold to cut read/write switching.
- Sits between the per-channel head/tail controllers and the shared memory port mux.

Parameters:
ports, 4, number of FIFO channels (≥1, need not be a power of 2)
burst, 4, max consecutive cycles one requester may hold the grant (≥1)
psz, $clog2(ports) (min 1), width of channel index
rsz, $clog2(2*ports), width of requester index

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
head_req  input  ports  bit i: channel i head wants a memory write cycle (producer srdy & !full)
tail_req  input  ports  bit i: channel i tail wants a memory read cycle (!empty & consumer can accept)
head_en  output  ports  bit i: enable to channel i head controller
tail_en  output  ports  bit i: enable to channel i tail controller
gnt_valid  output  1  a grant is issued this cycle
gnt_id  output  psz  channel index of current grant (0 when gnt_valid=0)
gnt_rd  output  1  1 = grant is to a tail (read), 0 = head (write)

Behaviour:
- Requester numbering: r=2i is head i, r=2i+1 is tail i; N=2*ports requesters.
- State: rr_ptr[rsz], fsm {IDLE, HOLD}, owner[rsz], cnt (counts 1..burst).
- Reset (reset=0, async):
  - rr_ptr=0, fsm=IDLE, owner=0, cnt=0.
  - All outputs forced 0 while reset is low, regardless of requests.
- Grant is combinational, zero latency: enables are valid in the same cycle as the req. Only pointer/state are registered.
- Arbitration (IDLE, or HOLD releasing):
  - Winner = first requesting r searching rr_ptr, rr_ptr+1, … mod N.
  - On a grant, rr_ptr <= (winner+1) mod N. Wrap uses an explicit compare at N-1, not power-of-2 overflow.
  - If burst>1: fsm <= HOLD, owner <= winner, cnt <= 1. Otherwise stay IDLE.
- HOLD:
  - If req[owner]=1 and cnt<burst: grant owner, cnt <= cnt+1, rr_ptr unchanged.
  - If req[owner]=0 or cnt==burst: arbitrate in the same cycle as IDLE, with no bubble cycle. The owner has lowest priority because rr_ptr is already past it.
  - If no other requester wins: fsm <= IDLE.
- No requests: all enables 0, gnt_valid=0, fsm <= IDLE, rr_ptr unchanged.
- Invariants:
  - popcount(head_en|tail_en) ≤ 1.
  - gnt_valid = |(head_en|tail_en).
  - gnt_id and gnt_rd are consistent with the one-hot enable.
- Fairness: with all 2*ports requesters continuously asserted, each receives exactly `burst` consecutive cycles per rotation of 2*ports*burst cycles.
- The scheduler is blind to full/empty. A requester must assert req only when its grant makes progress, otherwise the grant slot is wasted (no functional error).
- A req dropping mid-cycle after a grant is legal: the enable follows req combinationally.
- rr_ptr and owner never hold a value ≥N.

Optional Feature:
Macro SDLIB_SCHED_RDPRIO_EN.
- Defined: strict read priority. If any tail_req bit is high, only tail requesters compete:
  - Round-robin among tails uses rr_ptr restricted to odd r.
  - A head in HOLD is pre-empted in that cycle (fsm reloads with the tail winner).
  - Heads arbitrate only when tail_req==0.
- Not defined: single unified round-robin over all N requesters as above.

Test Plan:
1. Reset with head_req=4'hF held → all outputs 0 during reset. After release: head_en=0001 for 4 cycles, then 0010 for 4, then 0100 (ports=4, burst=4).
2. Only tail_req[2]=1 and head_req[0]=1, both held → tail_en=0100 for 4 cycles, then head_en=0001 for 4 cycles, alternating. No idle cycle between grants.
3. head_req[1] held 2 cycles then dropped while tail_req[3]=1 → head_en=0010 for 2 cycles, tail_en=1000 on cycle 3 with no bubble; gnt_id=3, gnt_rd=1.
4. burst=1, ports=3, all six reqs high → grant order r=0,1,2,3,4,5,0; rr_ptr wraps 5→0; gnt_id sequence 0,0,1,1,2,2,0.
5. Async reset asserted mid-HOLD (owner=r3, cnt=2) → outputs drop immediately. After release, first grant search starts at r0.
6. With SDLIB_SCHED_RDPRIO_EN: head_req=4'hF, tail_req[1] pulses 1 cycle mid-burst → that cycle tail_en=0010, head_en=0. Next cycle a head grant resumes.
